// File: rtl/trace_pkg.sv
// Shared definitions for the AXI trace capture unit: FSM encodings and timestamp width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// The STATE_* constants are the values shown in the register-window state field.
package trace_pkg;

    // Width of the optional per-sample cycle timestamp (TRACE_TIMESTAMP_EN builds).
    localparam int TS_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } trace_state_e;

    // Flat encodings used by the FSM and by software decoding state_o.
    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_PRE       = 3'd1;
    localparam logic [2:0] STATE_WAIT_TRIG = 3'd2;
    localparam logic [2:0] STATE_POST      = 3'd3;
    localparam logic [2:0] STATE_DONE      = 3'd4;

endpackage

// File: rtl/trace_ram_sdp.sv
// Simple dual-port capture RAM: one write port, one registered read port, both on clk.
// Latency: write lands at the clock edge; read data appears 1 cycle after rd_en_i.
// Backpressure: none; read data holds while rd_en_i is low.
// Ports: clk/rst_n; wr_en_i, wr_addr_i, wr_dat_i; rd_en_i, rd_addr_i, rd_dat_o.
// Only the read register is reset; the array itself keeps its contents through reset.
module trace_ram_sdp #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_dat_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_dat_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_dat_d;
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_dat_i;
        end
    end

    // Read-before-write on an address collision: the old word is returned.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en_i) begin
            rd_dat_d = mem[rd_addr_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/axi_trace_capture.sv
// AXI bus trace capture: match/mask trigger, pre-trigger ring buffer, post-trigger fill, logical readback.
// Latency: 1 cycle sample-to-memory, 1 cycle rd_en_i-to-rd_data_o.
// Backpressure: none; only sample_valid_i cycles are stored, everything holds when it is low.
// Ports: sample_i/sample_valid_i capture input; arm_i/abort_i/force_trig_i control pulses;
//        trig_mask_i/trig_value_i/pre_count_i configuration; rd_en_i/rd_addr_i/rd_data_o readback;
//        state_o/triggered_o/done_o/trig_ptr_o/wr_ptr_o status.
// Optional: define TRACE_TIMESTAMP_EN to store a cycle timestamp with each sample
//           (rd_data_o becomes {timestamp, sample}).
module axi_trace_capture
    import trace_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 256,
    parameter int DEPTH_LOG2   = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                    sample_valid_i,
    input  logic                    arm_i,
    input  logic                    abort_i,
    input  logic                    force_trig_i,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask_i,
    input  logic [SAMPLE_WIDTH-1:0] trig_value_i,
    input  logic [DEPTH_LOG2-1:0]   pre_count_i,
    input  logic                    rd_en_i,
    input  logic [DEPTH_LOG2-1:0]   rd_addr_i,
`ifdef TRACE_TIMESTAMP_EN
    output logic [SAMPLE_WIDTH+TS_WIDTH-1:0] rd_data_o,
`else
    output logic [SAMPLE_WIDTH-1:0] rd_data_o,
`endif
    output logic [2:0]              state_o,
    output logic                    triggered_o,
    output logic                    done_o,
    output logic [DEPTH_LOG2-1:0]   trig_ptr_o,
    output logic [DEPTH_LOG2-1:0]   wr_ptr_o
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int DATA_W = SAMPLE_WIDTH + TS_WIDTH;
`else
    localparam int DATA_W = SAMPLE_WIDTH;
`endif

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

    logic [2:0]            state_q,     state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,    wr_ptr_d;
    logic [DEPTH_LOG2-1:0] trig_ptr_q,  trig_ptr_d;
    logic [DEPTH_LOG2-1:0] pre_q,       pre_d;
    logic [DEPTH_LOG2-1:0] pre_cnt_q,   pre_cnt_d;
    logic [DEPTH_LOG2-1:0] post_cnt_q,  post_cnt_d;
    logic                  triggered_q, triggered_d;
    logic                  done_q,      done_d;

    logic                  capturing;
    logic                  wr_en;
    logic                  trig_hit;
    logic [DATA_W-1:0]     wr_dat;
    logic [DEPTH_LOG2-1:0] rd_phys;

    assign capturing = (state_q == STATE_PRE) || (state_q == STATE_WAIT_TRIG) ||
                       (state_q == STATE_POST);
    assign wr_en     = capturing && sample_valid_i;
    assign trig_hit  = (((sample_i ^ trig_value_i) & trig_mask_i) == '0) || force_trig_i;

    // Logical index 0 is the oldest retained pre-trigger sample.
    assign rd_phys = trig_ptr_q - pre_q + rd_addr_i;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if ((state_q == STATE_IDLE || state_q == STATE_DONE) && arm_i) begin
            ts_d = '0;
        end else if (capturing) begin
            ts_d = ts_q + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_dat = {ts_q, sample_i};
`else
    assign wr_dat = sample_i;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_ptr_d  = trig_ptr_q;
        pre_d       = pre_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        done_d      = done_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case (state_q)
            STATE_IDLE, STATE_DONE: begin
                if (arm_i) begin
                    wr_ptr_d    = '0;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    triggered_d = 1'b0;
                    done_d      = 1'b0;
                    pre_d       = pre_count_i;
                    state_d     = (pre_count_i != '0) ? STATE_PRE : STATE_WAIT_TRIG;
                end
            end
            STATE_PRE: begin
                if (sample_valid_i) begin
                    pre_cnt_d = pre_cnt_q + PTR_ONE;
                    if (pre_cnt_d == pre_q) begin
                        state_d = STATE_WAIT_TRIG;
                    end
                end
            end
            STATE_WAIT_TRIG: begin
                if (sample_valid_i && trig_hit) begin
                    trig_ptr_d  = wr_ptr_q;
                    triggered_d = 1'b1;
                    // The trigger sample itself occupies one of the post slots.
                    post_cnt_d  = PTR_MAX - pre_q;
                    if (post_cnt_d == '0) begin
                        state_d = STATE_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = STATE_POST;
                    end
                end
            end
            STATE_POST: begin
                if (sample_valid_i) begin
                    post_cnt_d = post_cnt_q - PTR_ONE;
                    if (post_cnt_d == '0) begin
                        state_d = STATE_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase

        // Abort wins over everything, including a simultaneous arm.
        if (abort_i) begin
            state_d     = STATE_IDLE;
            triggered_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            wr_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            pre_q       <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_ptr_q  <= trig_ptr_d;
            pre_q       <= pre_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
        end
    end

    trace_ram_sdp #(
        .WIDTH  (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (wr_dat),
        .rd_en_i   (rd_en_i),
        .rd_addr_i (rd_phys),
        .rd_dat_o  (rd_data_o)
    );

    assign state_o     = state_q;
    assign triggered_o = triggered_q;
    assign done_o      = done_q;
    assign trig_ptr_o  = trig_ptr_q;
    assign wr_ptr_o    = wr_ptr_q;

endmodule

// File: tb/tb_axi_trace_capture.sv
// Bench for axi_trace_capture with a 16-bit sample and a 16-entry buffer.
// Capture scenarios come from a vector table; readback goes through an expected-value queue.
// Abort-with-arm and asynchronous reset mid-capture are hand-written sequences.
module tb_axi_trace_capture;
    import trace_pkg::*;

    localparam int SW = 16;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sample_i;
    logic          sample_valid_i;
    logic          arm_i;
    logic          abort_i;
    logic          force_trig_i;
    logic [SW-1:0] trig_mask_i;
    logic [SW-1:0] trig_value_i;
    logic [DL-1:0] pre_count_i;
    logic          rd_en_i;
    logic [DL-1:0] rd_addr_i;
`ifdef TRACE_TIMESTAMP_EN
    logic [SW+TS_WIDTH-1:0] rd_data_o;
`else
    logic [SW-1:0] rd_data_o;
`endif
    logic [2:0]    state_o;
    logic          triggered_o;
    logic          done_o;
    logic [DL-1:0] trig_ptr_o;
    logic [DL-1:0] wr_ptr_o;

    axi_trace_capture #(.SAMPLE_WIDTH(SW), .DEPTH_LOG2(DL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .force_trig_i   (force_trig_i),
        .trig_mask_i    (trig_mask_i),
        .trig_value_i   (trig_value_i),
        .pre_count_i    (pre_count_i),
        .rd_en_i        (rd_en_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .state_o        (state_o),
        .triggered_o    (triggered_o),
        .done_o         (done_o),
        .trig_ptr_o     (trig_ptr_o),
        .wr_ptr_o       (wr_ptr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              pre;
        logic [SW-1:0]   mask;
        logic [SW-1:0]   value;
        int              force_at;
        bit              half;
        int              exp_trig_ptr;
        int              exp_first;
        int              exp_last;
        int              seq_len;
        logic [0:4][2:0] seq;
    } vec_t;

    vec_t          tbl [5];
    int            tests = 0;
    int            fails = 0;
    logic [SW-1:0] exp_q [$];
    logic [2:0]    sq [$];
    int            cyc_tbl [5];

    function automatic logic [SW-1:0] samp(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {~b, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the sample stream (value index 0,1,2,...) every cycle until state_o == target.
    task automatic drive_until(input logic [2:0] target, input int force_at, output bit ok);
        int idx;
        idx = 0;
        ok  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            sample_valid_i = 1'b1;
            sample_i       = samp(idx);
            force_trig_i   = (idx == force_at);
            @(posedge clk);
            #1;
            idx++;
            if (state_o == target) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        sample_valid_i = 1'b0;
        force_trig_i   = 1'b0;
    endtask

    task automatic run_capture(input int k);
        vec_t v;
        int   idx;
        int   cyc;
        bit   seq_ok;
        logic [SW-1:0] e;
        v = tbl[k];

        @(negedge clk);
        abort_i        = 1'b1;
        sample_valid_i = 1'b0;
        force_trig_i   = 1'b0;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        sq.delete();
        sq.push_back(state_o);

        @(negedge clk);
        arm_i        = 1'b1;
        pre_count_i  = DL'(v.pre);
        trig_mask_i  = v.mask;
        trig_value_i = v.value;
        @(posedge clk);
        #1;
        arm_i = 1'b0;
        if (state_o != sq[$]) sq.push_back(state_o);

        idx = 0;
        cyc = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            sample_valid_i = v.half ? (c % 2 == 0) : 1'b1;
            sample_i       = samp(idx);
            force_trig_i   = sample_valid_i && (idx == v.force_at);
            @(posedge clk);
            #1;
            cyc++;
            if (sample_valid_i) idx++;
            if (state_o != sq[$]) sq.push_back(state_o);
            if (done_o) break;
        end
        @(negedge clk);
        sample_valid_i = 1'b0;
        force_trig_i   = 1'b0;
        cyc_tbl[k]     = cyc;

        check($sformatf("v%0d done_o", k), 32'(done_o), 32'd1);
        check($sformatf("v%0d last_sample", k), 32'(idx - 1), 32'(v.exp_last));
        check($sformatf("v%0d trig_ptr", k), 32'(trig_ptr_o), 32'(v.exp_trig_ptr));
        check($sformatf("v%0d triggered", k), 32'(triggered_o), 32'd1);
        check($sformatf("v%0d wr_ptr", k), 32'(wr_ptr_o), 32'(idx % 16));
        seq_ok = (sq.size() == v.seq_len);
        for (int i = 0; i < v.seq_len && seq_ok; i++) begin
            if (sq[i] != v.seq[i]) seq_ok = 1'b0;
        end
        check($sformatf("v%0d state_seq", k), 32'(seq_ok), 32'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_en_i   = 1'b1;
            rd_addr_i = DL'(i);
            exp_q.push_back(samp(v.exp_first + i));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d rd[%0d]", k, i), 32'(rd_data_o[SW-1:0]), 32'(e));
        end
        @(negedge clk);
        rd_en_i   = 1'b0;
        rd_addr_i = DL'(3);
        @(posedge clk);
        #1;
        check($sformatf("v%0d rd_hold", k), 32'(rd_data_o[SW-1:0]), 32'(samp(v.exp_first + 15)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        //          pre  mask      value     force  half trig first  last  len  seq
        tbl[0] = '{4,  16'h00FF, 16'h002A, -1,    1'b0, 10, 'h26, 'h35, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}};
        tbl[1] = '{4,  16'h00FF, 16'h002A, -1,    1'b1, 10, 'h26, 'h35, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}};
        tbl[2] = '{0,  16'h0000, 16'h0000, -1,    1'b0, 0,  'h00, 'h0F, 4, {3'd0, 3'd2, 3'd3, 3'd4, 3'd0}};
        tbl[3] = '{15, 16'h00FF, 16'h0020, -1,    1'b0, 0,  'h11, 'h20, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0}};
        tbl[4] = '{4,  16'h00FF, 16'h002A, 'h10,  1'b0, 0,  'h0C, 'h1B, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}};

        rst_n          = 1'b0;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        arm_i          = 1'b0;
        abort_i        = 1'b0;
        force_trig_i   = 1'b0;
        trig_mask_i    = '0;
        trig_value_i   = '0;
        pre_count_i    = '0;
        rd_en_i        = 1'b0;
        rd_addr_i      = '0;

        #22;
        check("reset state", 32'(state_o), 32'(STATE_IDLE));
        check("reset triggered", 32'(triggered_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset trig_ptr", 32'(trig_ptr_o), 32'd0);
        check("reset wr_ptr", 32'(wr_ptr_o), 32'd0);
        check("reset rd_data", 32'(rd_data_o[SW-1:0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            run_capture(k);
        end
        check("half_rate_cycles",
              32'((cyc_tbl[1] >= 2 * cyc_tbl[0] - 3) && (cyc_tbl[1] <= 2 * cyc_tbl[0] + 3)), 32'd1);

        // Abort together with arm while in POST.
        @(negedge clk);
        arm_i        = 1'b1;
        pre_count_i  = DL'(4);
        trig_mask_i  = 16'h00FF;
        trig_value_i = 16'h002A;
        @(posedge clk);
        #1;
        arm_i = 1'b0;
        drive_until(STATE_POST, -1, ok);
        check("abort reach POST", 32'(ok), 32'd1);
        check("abort pre triggered", 32'(triggered_o), 32'd1);
        abort_i = 1'b1;
        arm_i   = 1'b1;
        @(posedge clk);
        #1;
        check("abort state", 32'(state_o), 32'(STATE_IDLE));
        check("abort done", 32'(done_o), 32'd0);
        check("abort triggered", 32'(triggered_o), 32'd0);
        @(negedge clk);
        abort_i = 1'b0;
        arm_i   = 1'b1;
        @(posedge clk);
        #1;
        arm_i = 1'b0;
        check("rearm wr_ptr", 32'(wr_ptr_o), 32'd0);
        check("rearm state", 32'(state_o), 32'(STATE_PRE));

        // Forced trigger on a non-matching sample, then asynchronous reset mid-POST.
        drive_until(STATE_POST, 'h10, ok);
        check("force reach POST", 32'(ok), 32'd1);
        check("force trig_ptr", 32'(trig_ptr_o), 32'd0);
        check("force triggered", 32'(triggered_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst state", 32'(state_o), 32'(STATE_IDLE));
        check("async rst triggered", 32'(triggered_o), 32'd0);
        check("async rst done", 32'(done_o), 32'd0);
        check("async rst trig_ptr", 32'(trig_ptr_o), 32'd0);
        check("async rst wr_ptr", 32'(wr_ptr_o), 32'd0);
        check("async rst rd_data", 32'(rd_data_o[SW-1:0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_trace_capture.md
Name: axi_trace_capture

Overview:
Parametrised AXI bus trace capture unit that generalises the debug wrapper's fixed 512-entry capture memory. It adds a programmable match/mask trigger, pre-trigger ring buffering, post-trigger fill, abort, and logical-order readback. It sits beside the debug AXI master, samples a packed bus-state vector every qualified cycle, and is read back through the JTAG-side register window.

Parameters:
SAMPLE_WIDTH, 256, bits per captured sample
DEPTH_LOG2, 9, log2 of buffer entries; DEPTH = 2**DEPTH_LOG2

Ports:
clk  in  1  capture and control clock
rst_n  in  1  asynchronous active-low reset
sample_i  in  SAMPLE_WIDTH  packed bus state to capture
sample_valid_i  in  1  qualifier; only qualified cycles are stored and counted
arm_i  in  1  single-cycle pulse; starts a capture
abort_i  in  1  single-cycle pulse; returns to IDLE
force_trig_i  in  1  treated as a trigger match in WAIT_TRIG
trig_mask_i  in  SAMPLE_WIDTH  bits participating in the match
trig_value_i  in  SAMPLE_WIDTH  match value
pre_count_i  in  DEPTH_LOG2  number of samples retained before the trigger; sampled on arm
rd_en_i  in  1  readback strobe
rd_addr_i  in  DEPTH_LOG2  logical index; 0 is the oldest sample
rd_data_o  out  SAMPLE_WIDTH(+TS_WIDTH)  readback data
state_o  out  3  current FSM state encoding
triggered_o  out  1  trigger seen in this capture
done_o  out  1  buffer complete
trig_ptr_o  out  DEPTH_LOG2  physical address of the trigger sample
wr_ptr_o  out  DEPTH_LOG2  next physical write address

Behaviour:
- Reset values: state IDLE (0), all pointers and counters 0, triggered_o 0, done_o 0, rd_data_o 0. Reset does not clear memory.
- States: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4.
- IDLE/DONE + arm_i:
  - wr_ptr, pre_cnt and post_cnt are cleared; triggered_o and done_o are cleared.
  - pre_count_i is latched as pre_q.
  - Next state is PRE if pre_q > 0, otherwise WAIT_TRIG.
  - arm_i in any other state is ignored.
- abort_i in any state → IDLE next cycle; done_o and triggered_o are cleared. abort_i beats arm_i when both are asserted in the same cycle.
- Writes occur in PRE, WAIT_TRIG and POST only, on sample_valid_i. Each write stores to mem[wr_ptr] and sets wr_ptr = wr_ptr+1 mod DEPTH (wraps freely). With sample_valid_i low, the state and all counters hold.
- PRE: each write increments pre_cnt. When the write makes pre_cnt == pre_q → WAIT_TRIG. Triggers are ignored in PRE.
- WAIT_TRIG: a trigger is a qualified cycle where ((sample_i ^ trig_value_i) & trig_mask_i) == 0, or where force_trig_i is high.
  - On a trigger, that sample is written, trig_ptr latches the current wr_ptr, and triggered_o rises.
  - post_cnt loads DEPTH-1-pre_q.
  - Next state is POST, or DONE if post_cnt would be 0.
  - An all-zero mask triggers on the first qualified sample.
- POST: each write decrements post_cnt. The write that takes it to 0 → DONE; done_o is high from the next cycle.
- pre_q = DEPTH-1 is legal: one post-trigger slot, which is the trigger sample itself, so the next state is DONE immediately.
- Readback:
  - Physical address = (trig_ptr - pre_q + rd_addr_i) mod DEPTH.
  - rd_data_o is registered and valid 1 cycle after rd_en_i; it holds when rd_en_i is low.
  - Reads are coherent only in DONE or IDLE after a completed capture. In other states, reads return the raw contents of the mapped address.
- Sample-to-readback latency: 1 cycle write, then 1 cycle read.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined:
  - A TS_WIDTH free-running counter clears on arm and increments every clk cycle in PRE, WAIT_TRIG and POST, wrapping modulo 2**TS_WIDTH.
  - The counter is stored alongside each sample; rd_data_o = {timestamp, sample}, SAMPLE_WIDTH+TS_WIDTH wide.
- Undefined: there is no counter, and rd_data_o is SAMPLE_WIDTH wide.

Decomposition:
- trace_pkg:
  - trace_state_e enum (IDLE..DONE, 3-bit).
  - TS_WIDTH = 32.
  - STATE_* localparams for register-window decode.
- One sub-module, trace_ram_sdp:
  - Parametrised simple dual-port RAM: one write port and one registered read port on clk, infers block RAM.
  - Width is SAMPLE_WIDTH(+TS_WIDTH), depth DEPTH.

Test Plan:
- DEPTH_LOG2=4, pre=4, mask=0xFF, value=0x2A, samples 0..63 valid every cycle → trigger on sample 0x2A; done after sample 0x35; reads 0..15 = 0x26..0x35; trig_ptr_o=10.
- Same setup with sample_valid_i toggled every other cycle → identical buffer contents; done asserted at about twice the cycle count.
- pre=0, mask=0 → first sample is the trigger; buffer = samples 0..15; state sequence IDLE→WAIT_TRIG→POST→DONE.
- pre=15, trigger on 0x20 → next state DONE directly after trigger; read index 15 = 0x20, index 0 = 0x11.
- abort_i in POST, with arm_i in the same cycle → IDLE, done_o=0, triggered_o=0; a subsequent arm starts cleanly with wr_ptr_o=0.
- force_trig_i in WAIT_TRIG with a non-matching pattern → trigger at that sample; rst_n dropped mid-POST → all outputs return to reset values asynchronously.
